nested_loop_counter: RTL and testbench

Parametrised three-level loop index generator for the accelerator's feature-map traversal. It runs a channel index (innermost), a column index and a row index (outermost). Bounds are loaded at runtime, and each counter advances on an external step strobe. It signals wrap-around per level and pulses completion. It replaces the fixed-length counter FSMs used by the convolution and pooling controllers.

---
 rtl/nested_loop_counter.sv | 140 ++++++++++++++
 tb/tb_nested_loop_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nested_loop_counter.sv
// Three-level (row/column/channel) loop index generator; channel innermost, bounds latched on start.
// All outputs registered, one edge after start/step/clear; step is the only pacing input, no backpressure.
module nested_loop_counter #(
    parameter int CH_W  = 2,
    parameter int COL_W = 10,
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic             step,
    input  logic [CH_W-1:0]  ch_last,
    input  logic [COL_W-1:0] col_last,
    input  logic [ROW_W-1:0] row_last,
    output logic [CH_W-1:0]  ch_idx,
    output logic [COL_W-1:0] col_idx,
    output logic [ROW_W-1:0] row_idx,
    output logic             busy,
    output logic             ch_first,
    output logic             ch_wrap,
    output logic             col_wrap,
    output logic             last,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CH_W-1:0]  ch_bound;
    logic [COL_W-1:0] col_bound;
    logic [ROW_W-1:0] row_bound;

    logic             ch_end;
    logic             col_end;
    logic             row_end;
    logic [CH_W-1:0]  ch_nxt;
    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row_nxt;

    // Wrap compares use the latched bounds, so counting never depends on field width.
    always_comb begin
        ch_end  = (ch_idx == ch_bound);
        col_end = (col_idx == col_bound);
        row_end = (row_idx == row_bound);
        ch_nxt  = ch_end ? '0 : ch_idx + CH_W'(1);
        col_nxt = col_idx;
        row_nxt = row_idx;
        if (ch_end) begin
            col_nxt = col_end ? '0 : col_idx + COL_W'(1);
            if (col_end) begin
                row_nxt = row_end ? '0 : row_idx + ROW_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ch_bound  <= '0;
            col_bound <= '0;
            row_bound <= '0;
            ch_idx    <= '0;
            col_idx   <= '0;
            row_idx   <= '0;
            busy      <= 1'b0;
            ch_first  <= 1'b0;
            ch_wrap   <= 1'b0;
            col_wrap  <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            ch_idx   <= '0;
            col_idx  <= '0;
            row_idx  <= '0;
            busy     <= 1'b0;
            ch_first <= 1'b0;
            ch_wrap  <= 1'b0;
            col_wrap <= 1'b0;
            last     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    ch_wrap  <= 1'b0;
                    col_wrap <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        ch_bound  <= ch_last;
                        col_bound <= col_last;
                        row_bound <= row_last;
                        ch_idx    <= '0;
                        col_idx   <= '0;
                        row_idx   <= '0;
                        busy      <= 1'b1;
                        ch_first  <= 1'b1;
                        last      <= (ch_last == '0) && (col_last == '0) && (row_last == '0);
                    end
                end
                RUN: begin
                    ch_wrap  <= 1'b0;
                    col_wrap <= 1'b0;
                    if (step) begin
                        ch_wrap  <= ch_end;
                        col_wrap <= ch_end && col_end;
                        if (last) begin
                            state    <= DONE;
                            ch_idx   <= '0;
                            col_idx  <= '0;
                            row_idx  <= '0;
                            busy     <= 1'b0;
                            ch_first <= 1'b0;
                            last     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            ch_idx   <= ch_nxt;
                            col_idx  <= col_nxt;
                            row_idx  <= row_nxt;
                            ch_first <= (ch_nxt == '0);
                            last     <= (ch_nxt == ch_bound) && (col_nxt == col_bound)
                                        && (row_nxt == row_bound);
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    ch_wrap  <= 1'b0;
                    col_wrap <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nested_loop_counter.sv
// Bench for nested_loop_counter: linear-step-count reference model compared against every output each cycle.
module tb_nested_loop_counter;

    localparam int CH_W  = 2;
    localparam int COL_W = 10;
    localparam int ROW_W = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             clear;
    logic             step;
    logic [CH_W-1:0]  ch_last;
    logic [COL_W-1:0] col_last;
    logic [ROW_W-1:0] row_last;
    logic [CH_W-1:0]  ch_idx;
    logic [COL_W-1:0] col_idx;
    logic [ROW_W-1:0] row_idx;
    logic             busy;
    logic             ch_first;
    logic             ch_wrap;
    logic             col_wrap;
    logic             last;
    logic             done;

    nested_loop_counter #(.CH_W(CH_W), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .step(step),
        .ch_last(ch_last), .col_last(col_last), .row_last(row_last),
        .ch_idx(ch_idx), .col_idx(col_idx), .row_idx(row_idx),
        .busy(busy), .ch_first(ch_first), .ch_wrap(ch_wrap), .col_wrap(col_wrap),
        .last(last), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: traversal position is a single step count k over C*L*R iterations.
    int m_c, m_l, m_r, m_k;
    bit m_run, m_done, m_chw, m_colw;

    int cnt_chw, cnt_colw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {4'b0, ch_idx, col_idx, row_idx, busy, ch_first, ch_wrap, col_wrap, last, done};
    endfunction

    function automatic logic [31:0] model_vec();
        int ch, col, row;
        bit first, lst;
        ch = 0; col = 0; row = 0; first = 0; lst = 0;
        if (m_run) begin
            ch    = m_k % m_c;
            col   = (m_k / m_c) % m_l;
            row   = m_k / (m_c * m_l);
            first = (ch == 0);
            lst   = (m_k == m_c * m_l * m_r - 1);
        end
        return {4'b0, ch[1:0], col[9:0], row[9:0], m_run, first, m_chw, m_colw, lst, m_done};
    endfunction

    function automatic logic [31:0] tuple(input int ch, input int col, input int row);
        return {10'b0, ch[1:0], col[9:0], row[9:0]};
    endfunction

    function automatic logic [31:0] dut_tuple();
        return {10'b0, ch_idx, col_idx, row_idx};
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_chw = 0; m_colw = 0; m_k = 0;
        m_c = 1; m_l = 1; m_r = 1;
    endtask

    task automatic model_clock(input bit st, input bit cl, input bit sp);
        bit was_done;
        was_done = m_done;
        m_done = 0; m_chw = 0; m_colw = 0;
        if (cl) begin
            m_run = 0;
        end else if (m_run) begin
            if (sp) begin
                m_k++;
                m_chw  = (m_k % m_c == 0);
                m_colw = (m_k % (m_c * m_l) == 0);
                if (m_k == m_c * m_l * m_r) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
        end else if (!was_done && st) begin
            m_c = int'(ch_last) + 1;
            m_l = int'(col_last) + 1;
            m_r = int'(row_last) + 1;
            m_k = 0;
            m_run = 1;
        end
    endtask

    task automatic cyc(input bit st, input bit cl, input bit sp);
        start = st; clear = cl; step = sp;
        @(posedge clk);
        model_clock(st, cl, sp);
        #1;
        check("outs", dut_vec(), model_vec());
        if (ch_wrap)  cnt_chw++;
        if (col_wrap) cnt_colw++;
    endtask

    task automatic set_bounds(input int c, input int l, input int r);
        ch_last = c[CH_W-1:0]; col_last = l[COL_W-1:0]; row_last = r[ROW_W-1:0];
    endtask

    initial begin
        int cycles, steps, max_col;
        bit sp;
        reset = 1; start = 0; clear = 0; step = 0;
        set_bounds(0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), 32'h0);
        reset = 0;

        // Reset mid-run at (1,5,2)
        set_bounds(3, 9, 4);
        cyc(1, 0, 0);
        repeat (1 + 5 * 4 + 2 * 40) cyc(0, 0, 1);
        check("pre_rst_tuple", dut_tuple(), tuple(1, 5, 2));
        reset = 1;
        #2;
        check("async_rst", dut_vec(), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        repeat (3) cyc(0, 0, 1);

        // Continuous step, 2x3x2
        set_bounds(1, 2, 1);
        cyc(1, 0, 0);
        check("t2_s0", dut_tuple(), tuple(0, 0, 0));
        cnt_chw = 0; cnt_colw = 0;
        cyc(0, 0, 1);
        check("t2_s1", dut_tuple(), tuple(1, 0, 0));
        cyc(0, 0, 1);
        check("t2_s2", dut_tuple(), tuple(0, 1, 0));
        repeat (10) cyc(0, 0, 1);
        check("t2_done", {31'b0, done}, 32'd1);
        check("t2_chwrap_cnt", cnt_chw, 32'd6);
        check("t2_colwrap_cnt", cnt_colw, 32'd2);
        cyc(0, 0, 1);
        check("t2_done_width", {31'b0, done}, 32'd0);

        // Toggling step
        cyc(1, 0, 0);
        cycles = 0; steps = 0;
        while (!done && cycles < 100) begin
            sp = cycles[0];
            cyc(0, 0, sp);
            cycles++;
            if (sp) steps++;
        end
        check("t3_cycles", cycles, 32'd24);
        check("t3_steps", steps, 32'd12);
        cyc(0, 0, 0);

        // Degenerate bounds
        set_bounds(0, 0, 0);
        cyc(1, 0, 0);
        check("t4_last", {31'b0, last}, 32'd1);
        cyc(0, 0, 1);
        check("t4_done", {31'b0, done}, 32'd1);
        cyc(0, 0, 0);
        check("t4_idle", {30'b0, busy, done}, 32'd0);

        // Large traversal, full column bound
        set_bounds(3, 639, 7);
        cyc(1, 0, 0);
        steps = 0; max_col = 0;
        while (!done && steps < 30000) begin
            cyc(0, 0, 1);
            steps++;
            if (busy && int'(col_idx) > max_col) max_col = int'(col_idx);
        end
        check("t5_steps", steps, 32'd20480);
        check("t5_max_col", max_col, 32'd639);
        cyc(0, 0, 0);

        // Clear mid-run at (2,100,7); start during RUN ignored
        set_bounds(3, 199, 9);
        cyc(1, 0, 0);
        repeat (2 + 100 * 4 + 7 * 800) cyc(0, 0, 1);
        check("t6_tuple", dut_tuple(), tuple(2, 100, 7));
        set_bounds(1, 3, 2);
        cyc(1, 0, 1);
        check("t6_start_ign", dut_tuple(), tuple(3, 100, 7));
        repeat (3) cyc(0, 0, 1);
        check("t6_no_relatch", dut_tuple(), tuple(2, 101, 7));
        cyc(0, 1, 1);
        check("t6_clear", dut_vec(), 32'h0);
        cyc(0, 0, 1);
        check("t6_no_done", {31'b0, done}, 32'd0);

        // Randomized bounds, step, start and clear
        for (int i = 0; i < 3000; i++) begin
            if (!busy) set_bounds($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
